// File: rtl/ar_sched_pkg.sv
// ---------------------------------------------------------------------------
// ar_sched_pkg
// Shared types and constants for the read-address scheduler.
//   state_t        : scheduler FSM state encoding
//   M0 / M1        : master index values, also the payload mux select values
//   DEF_MAX_OUTST  : default outstanding-burst limit per master
//   DEF_CNT_W      : default outstanding counter width
// ---------------------------------------------------------------------------
package ar_sched_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GNT_M0 = 2'd1,
        GNT_M1 = 2'd2
    } state_t;

    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

    localparam int DEF_MAX_OUTST = 4;
    localparam int DEF_CNT_W     = 3;

    // Round-robin hand-off: the master that just won yields priority.
    function automatic logic other_master(input logic m);
        return ~m;
    endfunction

endpackage

// File: rtl/ar_scheduler_outst_counter.sv
// ---------------------------------------------------------------------------
// outst_counter
// Tracks outstanding bursts for one master.
//   clk, rst : clock, asynchronous active-high reset
//   inc      : one burst issued this cycle
//   dec      : one burst completed this cycle
//   count    : current outstanding count (never exceeds MAX_OUTST)
//   full     : count has reached MAX_OUTST
//   err      : sticky, a completion arrived while count was 0
// ---------------------------------------------------------------------------
module outst_counter
    import ar_sched_pkg::*;
#(
    parameter int CNT_W     = DEF_CNT_W,
    parameter int MAX_OUTST = DEF_MAX_OUTST
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             err
);

    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_OUTST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
            err   <= 1'b0;
        end else begin
            // A completion with nothing outstanding is flagged even if an
            // issue lands in the same cycle; the count itself is untouched.
            if (dec && (count == '0))
                err <= 1'b1;

            if (inc && !dec) begin
                if (count < MAX_C)
                    count <= count + 1'b1;
            end else if (dec && !inc) begin
                if (count != '0)
                    count <= count - 1'b1;
            end
        end
    end

    assign full = (count >= MAX_C);

endmodule

// File: rtl/ar_scheduler.sv
// ---------------------------------------------------------------------------
// ar_scheduler
// Round-robin arbiter for a read-address channel shared by two masters.
// A grant is held until the AR handshake completes, followed by one
// mandatory IDLE cycle. Masters with MAX_OUTST bursts in flight are skipped.
//   clk, rst                    : clock, asynchronous active-high reset
//   ARVALID_M0 / ARVALID_M1     : address valid from each master
//   ARREADY_S                   : ready from the decoder side
//   RVALID/RREADY/RLAST_Mx      : read-data observation, burst completion
//   ARVALID_S                   : gated valid toward the decoder
//   ARREADY_M0 / ARREADY_M1     : gated ready back to each master
//   sel                         : payload mux select (0 = M0, 1 = M1)
//   outst_M0 / outst_M1         : outstanding burst counts
//   err                         : sticky completion-underflow flag
// ---------------------------------------------------------------------------
module ar_scheduler
    import ar_sched_pkg::*;
#(
    parameter int MAX_OUTST = DEF_MAX_OUTST,
    parameter int CNT_W     = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ARVALID_M0,
    input  logic             ARVALID_M1,
    input  logic             ARREADY_S,
    input  logic             RVALID_M0,
    input  logic             RREADY_M0,
    input  logic             RLAST_M0,
    input  logic             RVALID_M1,
    input  logic             RREADY_M1,
    input  logic             RLAST_M1,
    output logic             ARVALID_S,
    output logic             ARREADY_M0,
    output logic             ARREADY_M1,
    output logic             sel,
    output logic [CNT_W-1:0] outst_M0,
    output logic [CNT_W-1:0] outst_M1,
    output logic             err
);

    state_t state;
    state_t state_nxt;
    logic   prio;
    logic   prio_nxt;
    logic   sel_q;

    logic full_m0;
    logic full_m1;
    logic err_m0;
    logic err_m1;

    logic elig_m0;
    logic elig_m1;
    logic hs_m0;
    logic hs_m1;
    logic done_m0;
    logic done_m1;

    assign elig_m0 = ARVALID_M0 & ~full_m0;
    assign elig_m1 = ARVALID_M1 & ~full_m1;

    assign hs_m0 = (state == GNT_M0) & ARVALID_M0 & ARREADY_S;
    assign hs_m1 = (state == GNT_M1) & ARVALID_M1 & ARREADY_S;

    assign done_m0 = RVALID_M0 & RREADY_M0 & RLAST_M0;
    assign done_m1 = RVALID_M1 & RREADY_M1 & RLAST_M1;

    always_comb begin
        state_nxt = state;
        prio_nxt  = prio;
        case (state)
            IDLE: begin
                if (elig_m0 && elig_m1)
                    state_nxt = (prio == M1) ? GNT_M1 : GNT_M0;
                else if (elig_m0)
                    state_nxt = GNT_M0;
                else if (elig_m1)
                    state_nxt = GNT_M1;
            end
            GNT_M0: begin
                // Valid withdrawn before handshake: release without
                // touching priority or the count.
                if (!ARVALID_M0) begin
                    state_nxt = IDLE;
                end else if (ARREADY_S) begin
                    state_nxt = IDLE;
                    prio_nxt  = other_master(M0);
                end
            end
            GNT_M1: begin
                if (!ARVALID_M1) begin
                    state_nxt = IDLE;
                end else if (ARREADY_S) begin
                    state_nxt = IDLE;
                    prio_nxt  = other_master(M1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            prio  <= M0;
            sel_q <= M0;
        end else begin
            state <= state_nxt;
            prio  <= prio_nxt;
            // Select is loaded on grant entry so it is already stable when
            // the granted master's payload reaches the mux, and it holds
            // through IDLE.
            if (state == IDLE) begin
                if (state_nxt == GNT_M0)
                    sel_q <= M0;
                else if (state_nxt == GNT_M1)
                    sel_q <= M1;
            end
        end
    end

    always_comb begin
        ARVALID_S  = 1'b0;
        ARREADY_M0 = 1'b0;
        ARREADY_M1 = 1'b0;
        case (state)
            GNT_M0: begin
                ARVALID_S  = ARVALID_M0;
                ARREADY_M0 = ARREADY_S;
            end
            GNT_M1: begin
                ARVALID_S  = ARVALID_M1;
                ARREADY_M1 = ARREADY_S;
            end
            default: ;
        endcase
    end

    assign sel = sel_q;

    outst_counter #(
        .CNT_W     (CNT_W),
        .MAX_OUTST (MAX_OUTST)
    ) u_cnt_m0 (
        .clk   (clk),
        .rst   (rst),
        .inc   (hs_m0),
        .dec   (done_m0),
        .count (outst_M0),
        .full  (full_m0),
        .err   (err_m0)
    );

    outst_counter #(
        .CNT_W     (CNT_W),
        .MAX_OUTST (MAX_OUTST)
    ) u_cnt_m1 (
        .clk   (clk),
        .rst   (rst),
        .inc   (hs_m1),
        .dec   (done_m1),
        .count (outst_M1),
        .full  (full_m1),
        .err   (err_m1)
    );

    assign err = err_m0 | err_m1;

endmodule

// File: tb/tb_ar_scheduler.sv
// ---------------------------------------------------------------------------
// tb_ar_scheduler
// Scoreboard bench for ar_scheduler. A transaction-level model predicts,
// for every driven cycle, the visible outputs and any AR handshake; the
// predictions are queued and a separate monitor compares them against the
// DUT half a cycle later.
// ---------------------------------------------------------------------------
module tb_ar_scheduler;

    localparam int MAX_OUTST = 4;
    localparam int CNT_W     = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ARVALID_M0 = 0, ARVALID_M1 = 0, ARREADY_S = 0;
    logic RVALID_M0 = 0, RREADY_M0 = 0, RLAST_M0 = 0;
    logic RVALID_M1 = 0, RREADY_M1 = 0, RLAST_M1 = 0;
    logic ARVALID_S, ARREADY_M0, ARREADY_M1, sel, err;
    logic [CNT_W-1:0] outst_M0, outst_M1;

    always #5 clk = ~clk;

    ar_scheduler #(.MAX_OUTST(MAX_OUTST), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .ARVALID_M0(ARVALID_M0), .ARVALID_M1(ARVALID_M1), .ARREADY_S(ARREADY_S),
        .RVALID_M0(RVALID_M0), .RREADY_M0(RREADY_M0), .RLAST_M0(RLAST_M0),
        .RVALID_M1(RVALID_M1), .RREADY_M1(RREADY_M1), .RLAST_M1(RLAST_M1),
        .ARVALID_S(ARVALID_S), .ARREADY_M0(ARREADY_M0), .ARREADY_M1(ARREADY_M1),
        .sel(sel), .outst_M0(outst_M0), .outst_M1(outst_M1), .err(err)
    );

    typedef struct {
        int avs;
        int ar0;
        int ar1;
        int sel;
        int o0;
        int o1;
        int err;
    } stat_t;

    stat_t sq[$];
    int    hq[$];

    int checks = 0;
    int passes = 0;

    // Model: who holds the channel (-1 = nobody), whose turn it is on a tie,
    // last granted master, bursts in flight per master, sticky error.
    int owner = -1;
    int prio  = 0;
    int msel  = 0;
    int cnt[2];
    int merr  = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        owner  = -1;
        prio   = 0;
        msel   = 0;
        cnt[0] = 0;
        cnt[1] = 0;
        merr   = 0;
    endtask

    function automatic stat_t zero_stat();
        stat_t s;
        s.avs = 0; s.ar0 = 0; s.ar1 = 0; s.sel = 0; s.o0 = 0; s.o1 = 0; s.err = 0;
        return s;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        {ARVALID_M0, ARVALID_M1, ARREADY_S} = 3'b000;
        {RVALID_M0, RREADY_M0, RLAST_M0} = 3'b000;
        {RVALID_M1, RREADY_M1, RLAST_M1} = 3'b000;
        model_reset();
        sq.push_back(zero_stat());
    endtask

    // r0/r1 = {RVALID, RREADY, RLAST}
    task automatic drive_cycle(input bit av0, input bit av1, input bit ars,
                               input bit [2:0] r0, input bit [2:0] r1);
        int    av[2];
        int    done[2];
        int    elig[2];
        int    hs;
        int    inc;
        stat_t s;
        @(negedge clk);
        rst = 1'b0;
        ARVALID_M0 = av0; ARVALID_M1 = av1; ARREADY_S = ars;
        {RVALID_M0, RREADY_M0, RLAST_M0} = r0;
        {RVALID_M1, RREADY_M1, RLAST_M1} = r1;
        av[0] = av0; av[1] = av1;
        done[0] = (r0 == 3'b111); done[1] = (r1 == 3'b111);

        s = zero_stat();
        if (owner >= 0) begin
            s.avs = av[owner];
            if (owner == 0) s.ar0 = ars; else s.ar1 = ars;
        end
        s.sel = msel; s.o0 = cnt[0]; s.o1 = cnt[1]; s.err = merr;
        sq.push_back(s);

        hs = (owner >= 0) && av[owner] && ars;
        if (hs) hq.push_back(owner);

        for (int i = 0; i < 2; i++) elig[i] = av[i] && (cnt[i] < MAX_OUTST);
        for (int i = 0; i < 2; i++) begin
            inc = hs && (owner == i);
            if (done[i] && cnt[i] == 0) merr = 1;
            if (inc && !done[i] && cnt[i] < MAX_OUTST) cnt[i]++;
            else if (done[i] && !inc && cnt[i] > 0) cnt[i]--;
        end

        if (owner >= 0) begin
            if (hs) begin
                prio  = 1 - owner;
                owner = -1;
            end else if (!av[owner]) begin
                owner = -1;
            end
        end else begin
            if (elig[0] && elig[1]) owner = prio;
            else if (elig[0])       owner = 0;
            else if (elig[1])       owner = 1;
            if (owner >= 0) msel = owner;
        end
    endtask

    // Monitor: compares queued predictions against the DUT mid-cycle.
    initial begin
        stat_t s;
        int    m;
        forever begin
            @(negedge clk);
            #2;
            if (sq.size() > 0) begin
                s = sq.pop_front();
                chk("ARVALID_S",  int'(ARVALID_S),  s.avs);
                chk("ARREADY_M0", int'(ARREADY_M0), s.ar0);
                chk("ARREADY_M1", int'(ARREADY_M1), s.ar1);
                chk("sel",        int'(sel),        s.sel);
                chk("outst_M0",   int'(outst_M0),   s.o0);
                chk("outst_M1",   int'(outst_M1),   s.o1);
                chk("err",        int'(err),        s.err);
            end
            if (ARVALID_S && ARREADY_S) begin
                if (hq.size() == 0) begin
                    checks++;
                    $display("FAIL hs_unexpected: DUT handshake with sel=%0d, none required at %0t", sel, $time);
                end else begin
                    m = hq.pop_front();
                    chk("hs_master", int'(sel), m);
                    chk("hs_ready", (m == 1) ? int'(ARREADY_M1) : int'(ARREADY_M0), 1);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit [2:0] r0, r1;
        bit       a0, a1, ar;

        // Single grant to M0 and resulting count.
        do_reset();
        drive_cycle(1, 0, 1, 0, 0);
        drive_cycle(1, 0, 1, 0, 0);
        #2 chk("dir_first_gnt_sel", int'(sel), 0);
        chk("dir_first_gnt_avs", int'(ARVALID_S), 1);
        drive_cycle(0, 0, 0, 0, 0);
        #2 chk("dir_first_outst", int'(outst_M0), 1);
        drive_cycle(1, 1, 1, 0, 0);   // prio now M1
        drive_cycle(1, 1, 1, 0, 0);
        #2 chk("dir_prio_m1", int'(sel), 1);

        // Alternation with both masters requesting continuously.
        do_reset();
        repeat (8) drive_cycle(1, 1, 1, 0, 0);
        drive_cycle(0, 0, 0, 0, 0);
        #2 chk("dir_alt_m0", int'(outst_M0), 2);
        chk("dir_alt_m1", int'(outst_M1), 2);

        // M0 saturates at MAX_OUTST, M1 still served, release re-enables M0.
        do_reset();
        repeat (8) drive_cycle(1, 0, 1, 0, 0);
        drive_cycle(1, 0, 1, 0, 0);
        #2 chk("dir_full_cnt", int'(outst_M0), 4);
        chk("dir_full_blocked", int'(ARVALID_S), 0);
        drive_cycle(1, 1, 1, 0, 0);
        drive_cycle(1, 1, 1, 0, 0);
        #2 chk("dir_full_m1_gnt", int'(sel), 1);
        drive_cycle(1, 0, 1, 3'b111, 0);
        drive_cycle(1, 0, 1, 0, 0);
        #2 chk("dir_full_dec", int'(outst_M0), 3);
        drive_cycle(1, 0, 1, 0, 0);
        #2 chk("dir_full_regrant", int'(sel), 0);
        chk("dir_full_regrant_avs", int'(ARVALID_S), 1);

        // Simultaneous issue and completion on M1 at count 2.
        drive_cycle(0, 1, 1, 0, 0);
        drive_cycle(0, 1, 1, 0, 0);
        drive_cycle(0, 0, 0, 0, 0);
        drive_cycle(0, 1, 1, 0, 0);
        drive_cycle(0, 1, 1, 0, 3'b111);
        drive_cycle(0, 0, 0, 0, 0);
        #2 chk("dir_incdec", int'(outst_M1), 2);

        // Underflow sets sticky err.
        do_reset();
        drive_cycle(0, 0, 0, 3'b111, 0);
        drive_cycle(0, 0, 0, 0, 0);
        #2 chk("dir_uflow_err", int'(err), 1);
        chk("dir_uflow_cnt", int'(outst_M0), 0);
        repeat (3) drive_cycle(0, 0, 0, 0, 0);
        do_reset();
        drive_cycle(0, 0, 0, 0, 0);

        // Reset while M1 holds the grant with ARREADY_S low.
        drive_cycle(0, 1, 0, 0, 0);
        drive_cycle(0, 1, 0, 0, 0);
        #3 chk("dir_rst_pre_avs", int'(ARVALID_S), 1);
        rst = 1'b1;
        #1 chk("dir_rst_avs", int'(ARVALID_S), 0);
        chk("dir_rst_ar1", int'(ARREADY_M1), 0);
        model_reset();
        drive_cycle(1, 1, 1, 0, 0);
        drive_cycle(1, 1, 1, 0, 0);
        #2 chk("dir_rst_prio", int'(sel), 0);

        // Randomized traffic.
        for (int n = 0; n < 2000; n++) begin
            a0 = ($urandom_range(3) != 0);
            a1 = ($urandom_range(3) != 0);
            ar = $urandom_range(1);
            r0 = 3'($urandom_range(6));
            r1 = 3'($urandom_range(6));
            if ($urandom_range(3) == 0 && (cnt[0] > 0 || $urandom_range(31) == 0)) r0 = 3'b111;
            if ($urandom_range(3) == 0 && (cnt[1] > 0 || $urandom_range(31) == 0)) r1 = 3'b111;
            if ($urandom_range(499) == 0) do_reset();
            else drive_cycle(a0, a1, ar, r0, r1);
        end

        repeat (3) drive_cycle(0, 0, 0, 0, 0);
        @(negedge clk);
        #4;
        chk("sq_drained", sq.size(), 0);
        chk("hq_drained", hq.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
